// File: rtl/dmi_dtm_core.sv
// ============================================================================
// Module      : dmi_dtm_core
// Description : JTAG DTM core: dtmcs/DMI data registers and DMI request FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmi_dtm_core #(
   parameter int unsigned AddrWidth     = 7,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned IdleHint      = 1,
   parameter int unsigned TimeoutCycles = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 capture_i,
   input  logic                 shift_i,
   input  logic                 update_i,
   input  logic                 tdi_i,
   input  logic                 dtmcs_select_i,
   input  logic                 dmi_select_i,
   input  logic                 tap_clear_i,
   output logic                 dtmcs_tdo_o,
   output logic                 dmi_tdo_o,
   output logic                 dmi_req_valid_o,
   input  logic                 dmi_req_ready_i,
   output logic [AddrWidth-1:0] dmi_req_addr_o,
   output logic [DataWidth-1:0] dmi_req_data_o,
   output logic [1:0]           dmi_req_op_o,
   input  logic                 dmi_resp_valid_i,
   output logic                 dmi_resp_ready_o,
   input  logic [DataWidth-1:0] dmi_resp_data_i,
   input  logic [1:0]           dmi_resp_resp_i,
   output logic                 dmi_clear_o
);

   localparam int unsigned c_dr_width = AddrWidth + DataWidth + 2;

   localparam logic [2:0] c_st_idle       = 3'd0;
   localparam logic [2:0] c_st_read       = 3'd1;
   localparam logic [2:0] c_st_wait_read  = 3'd2;
   localparam logic [2:0] c_st_write      = 3'd3;
   localparam logic [2:0] c_st_wait_write = 3'd4;

   localparam logic [1:0] c_err_none   = 2'd0;
   localparam logic [1:0] c_err_failed = 2'd2;
   localparam logic [1:0] c_err_busy   = 2'd3;

   localparam logic [DataWidth-1:0] c_data_failed = DataWidth'(32'hDEADBEEF);
   localparam logic [DataWidth-1:0] c_data_busy   = DataWidth'(32'hB051B051);
   localparam logic                 c_tmo_en      = (TimeoutCycles != 0);
   localparam logic [15:0]          c_tmo_last    = 16'(TimeoutCycles - 1);

   logic [2:0]            r_state, w_state_n;
   logic [AddrWidth-1:0]  r_addr, w_addr_n;
   logic [DataWidth-1:0]  r_data, w_data_n;
   logic [1:0]            r_error, w_error_n;
   logic [15:0]           r_tmo_cnt, w_tmo_cnt_n;
   logic [31:0]           r_dtmcs;
   logic [c_dr_width-1:0] r_dr;
   logic                  w_busy, w_resp_busy, w_fail, w_dmireset, w_dmi_clear;
   logic [1:0]            w_capture_op;

   assign w_dmi_clear = tap_clear_i | (update_i & dtmcs_select_i & r_dtmcs[17]);
   assign w_dmireset  = update_i & dtmcs_select_i & r_dtmcs[16];

   assign dmi_clear_o      = tap_clear_i | (~rst_i & update_i & dtmcs_select_i & r_dtmcs[17]);
   assign dmi_resp_ready_o = 1'b1;
   assign dtmcs_tdo_o      = r_dtmcs[0] & ~rst_i;
   assign dmi_tdo_o        = r_dr[0] & ~rst_i;
   assign dmi_req_valid_o  = ~rst_i & ((r_state == c_st_read) | (r_state == c_st_write));
   assign dmi_req_addr_o   = r_addr;
   assign dmi_req_data_o   = r_data;
   assign dmi_req_op_o     = (r_state == c_st_write) ? 2'd2 : 2'd1;

   always_comb begin
      w_state_n   = r_state;
      w_addr_n    = r_addr;
      w_data_n    = r_data;
      w_tmo_cnt_n = r_tmo_cnt;
      w_fail      = 1'b0;
      w_resp_busy = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (update_i && dmi_select_i && (r_error == c_err_none)) begin
               w_addr_n = r_dr[c_dr_width-1 -: AddrWidth];
               w_data_n = r_dr[DataWidth+1:2];
               if (r_dr[1:0] == 2'd1)      w_state_n = c_st_read;
               else if (r_dr[1:0] == 2'd2) w_state_n = c_st_write;
            end
         end
         c_st_read: begin
            if (dmi_req_ready_i) begin
               w_state_n   = c_st_wait_read;
               w_tmo_cnt_n = '0;
            end
         end
         c_st_write: begin
            if (dmi_req_ready_i) begin
               w_state_n   = c_st_wait_write;
               w_tmo_cnt_n = '0;
            end
         end
         c_st_wait_read: begin
            if (dmi_resp_valid_i) begin
               w_state_n = c_st_idle;
               if (dmi_resp_resp_i == c_err_busy) begin
                  w_data_n    = c_data_busy;
                  w_resp_busy = 1'b1;
               end else if (dmi_resp_resp_i == c_err_failed) begin
                  w_data_n = c_data_failed;
                  w_fail   = 1'b1;
               end else begin
                  w_data_n = dmi_resp_data_i;
               end
            end else if (c_tmo_en) begin
               if (r_tmo_cnt == c_tmo_last) begin
                  w_state_n = c_st_idle;
                  w_data_n  = c_data_failed;
                  w_fail    = 1'b1;
               end else begin
                  w_tmo_cnt_n = r_tmo_cnt + 16'd1;
               end
            end
         end
         c_st_wait_write: begin
            if (dmi_resp_valid_i) begin
               w_state_n   = c_st_idle;
               w_resp_busy = (dmi_resp_resp_i == c_err_busy);
               w_fail      = (dmi_resp_resp_i == c_err_failed);
            end else if (c_tmo_en) begin
               if (r_tmo_cnt == c_tmo_last) begin
                  w_state_n = c_st_idle;
                  w_fail    = 1'b1;
               end else begin
                  w_tmo_cnt_n = r_tmo_cnt + 16'd1;
               end
            end
         end
         default: w_state_n = c_st_idle;
      endcase

      // Host touched the DMI while a transaction was outstanding
      w_busy = (update_i && dmi_select_i && (r_state != c_st_idle)) ||
               (capture_i && dmi_select_i &&
                ((r_state == c_st_read) || (r_state == c_st_wait_read)));

      w_error_n = r_error;
      if (r_error == c_err_none) begin
         if (w_busy || w_resp_busy) w_error_n = c_err_busy;
         else if (w_fail)           w_error_n = c_err_failed;
      end
      if (w_dmireset) w_error_n = c_err_none;

      w_capture_op = w_busy ? c_err_busy : r_error;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= c_st_idle;
         r_addr    <= '0;
         r_data    <= '0;
         r_error   <= '0;
         r_tmo_cnt <= '0;
         r_dr      <= '0;
      end else if (w_dmi_clear) begin
         r_state   <= c_st_idle;
         r_addr    <= '0;
         r_data    <= '0;
         r_error   <= '0;
         r_tmo_cnt <= '0;
         r_dr      <= '0;
      end else begin
         r_state   <= w_state_n;
         r_addr    <= w_addr_n;
         r_data    <= w_data_n;
         r_error   <= w_error_n;
         r_tmo_cnt <= w_tmo_cnt_n;
         if (capture_i && dmi_select_i)    r_dr <= {r_addr, r_data, w_capture_op};
         else if (shift_i && dmi_select_i) r_dr <= {tdi_i, r_dr[c_dr_width-1:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_dtmcs <= '0;
      end else if (capture_i && dtmcs_select_i) begin
         r_dtmcs <= {14'b0, 2'b00, 1'b0, 3'(IdleHint), r_error, 6'(AddrWidth), 4'd1};
      end else if (shift_i && dtmcs_select_i) begin
         r_dtmcs <= {tdi_i, r_dtmcs[31:1]};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmi_dtm_core.sv
// ============================================================================
// Module      : tb_dmi_dtm_core
// Description : Directed self-checking bench; instance A (7/32, timeout 8), B (10/64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmi_dtm_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, capture, shift, update, tdi, dtmcs_sel, dmi_sel, tap_clear;
   logic        req_ready, resp_valid, sel_b;
   logic [63:0] resp_data;
   logic [1:0]  resp_resp;
   int          checks = 0;
   int          errors = 0;
   int          wr_hs  = 0;

   logic        dtmcs_tdo_a, dmi_tdo_a, valid_a, resp_ready_a, clear_a;
   logic [6:0]  addr_a;
   logic [31:0] data_a;
   logic [1:0]  op_a;
   logic        dtmcs_tdo_b, dmi_tdo_b, valid_b, resp_ready_b, clear_b;
   logic [9:0]  addr_b;
   logic [63:0] data_b;
   logic [1:0]  op_b;

   wire tdo_mux = sel_b ? (dtmcs_sel ? dtmcs_tdo_b : dmi_tdo_b)
                        : (dtmcs_sel ? dtmcs_tdo_a : dmi_tdo_a);
   wire clr_mux = sel_b ? clear_b : clear_a;

   dmi_dtm_core #(.AddrWidth(7), .DataWidth(32), .IdleHint(1), .TimeoutCycles(8)) u_dut_a (
      .clk_i(clk), .rst_i(rst),
      .capture_i(capture & ~sel_b), .shift_i(shift & ~sel_b), .update_i(update & ~sel_b),
      .tdi_i(tdi), .dtmcs_select_i(dtmcs_sel), .dmi_select_i(dmi_sel), .tap_clear_i(tap_clear),
      .dtmcs_tdo_o(dtmcs_tdo_a), .dmi_tdo_o(dmi_tdo_a),
      .dmi_req_valid_o(valid_a), .dmi_req_ready_i(req_ready & ~sel_b),
      .dmi_req_addr_o(addr_a), .dmi_req_data_o(data_a), .dmi_req_op_o(op_a),
      .dmi_resp_valid_i(resp_valid & ~sel_b), .dmi_resp_ready_o(resp_ready_a),
      .dmi_resp_data_i(resp_data[31:0]), .dmi_resp_resp_i(resp_resp),
      .dmi_clear_o(clear_a)
   );

   dmi_dtm_core #(.AddrWidth(10), .DataWidth(64), .IdleHint(1), .TimeoutCycles(0)) u_dut_b (
      .clk_i(clk), .rst_i(rst),
      .capture_i(capture & sel_b), .shift_i(shift & sel_b), .update_i(update & sel_b),
      .tdi_i(tdi), .dtmcs_select_i(dtmcs_sel), .dmi_select_i(dmi_sel), .tap_clear_i(tap_clear),
      .dtmcs_tdo_o(dtmcs_tdo_b), .dmi_tdo_o(dmi_tdo_b),
      .dmi_req_valid_o(valid_b), .dmi_req_ready_i(req_ready & sel_b),
      .dmi_req_addr_o(addr_b), .dmi_req_data_o(data_b), .dmi_req_op_o(op_b),
      .dmi_resp_valid_i(resp_valid & sel_b), .dmi_resp_ready_o(resp_ready_b),
      .dmi_resp_data_i(resp_data), .dmi_resp_resp_i(resp_resp),
      .dmi_clear_o(clear_b)
   );

   // Accepted write requests on instance A
   always @(posedge clk) if (valid_a && req_ready && !sel_b && op_a == 2'd2) wr_hs++;

   function automatic logic [75:0] mk_a(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
      return {35'b0, a, d, op};
   endfunction

   function automatic logic [75:0] mk_b(input logic [9:0] a, input logic [63:0] d, input logic [1:0] op);
      return {a, d, op};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Capture, shift len bits (LSB first), update; returns shifted-out bits and dmi_clear during update.
   task automatic scan(input bit dt, input int len, input logic [75:0] din,
                       output logic [75:0] dout, output logic clr);
      dout = '0;
      dtmcs_sel = dt;
      dmi_sel = !dt;
      capture = 1'b1; tick(); capture = 1'b0;
      shift = 1'b1;
      for (int i = 0; i < len; i++) begin
         dout[i] = tdo_mux;
         tdi = din[i];
         tick();
      end
      shift = 1'b0;
      update = 1'b1;
      #1 clr = clr_mux;
      tick();
      update = 1'b0; dtmcs_sel = 1'b0; dmi_sel = 1'b0; tdi = 1'b0;
   endtask

   task automatic resp_cycle(input logic [63:0] d, input logic [1:0] r);
      resp_data = d; resp_resp = r; resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [75:0] dout;
      logic        clr;
      rst = 1'b1; capture = 0; shift = 0; update = 0; tdi = 0; dtmcs_sel = 0; dmi_sel = 0;
      tap_clear = 0; req_ready = 0; resp_valid = 0; sel_b = 0; resp_data = '0; resp_resp = '0;

      // Reset state
      @(negedge clk);
      chk("rst_valid", valid_a, 1'b0);
      chk("rst_resp_ready", resp_ready_a, 1'b1);
      chk("rst_clear", clear_a, 1'b0);
      chk("rst_tdo", {dtmcs_tdo_a, dmi_tdo_a}, 2'b00);
      tap_clear = 1'b1; #1;
      chk("tap_clear", clear_a, 1'b1);
      tap_clear = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_valid", valid_a, 1'b0);
      chk("post_rst_tdo", {dtmcs_tdo_a, dmi_tdo_a}, 2'b00);

      // Write 0x12345678 to 0x10
      scan(0, 41, mk_a(7'h10, 32'h12345678, 2'd2), dout, clr);
      chk("wr_valid", valid_a, 1'b1);
      chk("wr_req", {addr_a, data_a, op_a}, mk_a(7'h10, 32'h12345678, 2'd2));
      req_ready = 1'b1; tick(); req_ready = 1'b0;
      chk("wr_accepted", valid_a, 1'b0);
      resp_cycle(64'h0, 2'd0);
      scan(0, 41, mk_a(0, 0, 0), dout, clr);
      chk("wr_capture", dout, mk_a(7'h10, 32'h12345678, 2'd0));
      chk("wr_once", wr_hs, 1);

      // Read 0x11 returning 0xCAFEF00D
      scan(0, 41, mk_a(7'h11, 0, 2'd1), dout, clr);
      chk("rd_req", {valid_a, addr_a, op_a}, {1'b1, 7'h11, 2'd1});
      req_ready = 1'b1; tick(); req_ready = 1'b0;
      resp_cycle(64'hCAFEF00D, 2'd0);
      scan(0, 41, mk_a(0, 0, 0), dout, clr);
      chk("rd_capture", dout, mk_a(7'h11, 32'hCAFEF00D, 2'd0));

      // Capture during WaitRead -> busy, sticky until dmireset
      scan(0, 41, mk_a(7'h12, 0, 2'd1), dout, clr);
      req_ready = 1'b1; tick(); req_ready = 1'b0;
      scan(0, 41, mk_a(0, 0, 0), dout, clr);
      chk("busy_capture", dout, mk_a(7'h12, 32'h0, 2'd3));
      scan(0, 41, mk_a(7'h13, 32'hAAAA5555, 2'd2), dout, clr);
      chk("sticky_capture", dout, mk_a(7'h12, 32'hDEADBEEF, 2'd3));
      chk("sticky_ignored", valid_a, 1'b0);
      scan(1, 32, 76'h10000, dout, clr);
      chk("dtmcs_busy", dout, 76'h1C71);
      scan(1, 32, 76'h0, dout, clr);
      chk("dtmcs_cleared", dout, 76'h1071);
      scan(0, 41, mk_a(0, 0, 0), dout, clr);
      chk("cleared_op", dout, mk_a(7'h12, 32'hDEADBEEF, 2'd0));

      // Read timeout after 8 wait cycles
      scan(0, 41, mk_a(7'h14, 0, 2'd1), dout, clr);
      req_ready = 1'b1; tick(); req_ready = 1'b0;
      repeat (6) tick();
      scan(1, 32, 76'h0, dout, clr);
      chk("tmo_not_yet", dout, 76'h1071);
      scan(0, 41, mk_a(0, 0, 0), dout, clr);
      chk("tmo_capture", dout, mk_a(7'h14, 32'hDEADBEEF, 2'd2));
      scan(1, 32, 76'h10000, dout, clr);
      chk("tmo_dmistat", dout, 76'h1871);

      // Busy response on a read
      scan(0, 41, mk_a(7'h16, 0, 2'd1), dout, clr);
      req_ready = 1'b1; tick(); req_ready = 1'b0;
      resp_cycle(64'h0, 2'd3);
      scan(0, 41, mk_a(0, 0, 0), dout, clr);
      chk("resp_busy", dout, mk_a(7'h16, 32'hB051B051, 2'd3));
      scan(1, 32, 76'h10000, dout, clr);
      chk("resp_busy_dtmcs", dout, 76'h1C71);

      // dmihardreset during Write
      scan(0, 41, mk_a(7'h15, 32'h55, 2'd2), dout, clr);
      chk("hr_valid", valid_a, 1'b1);
      scan(0, 41, mk_a(0, 0, 0), dout, clr);
      chk("hr_pre_capture", dout, mk_a(7'h15, 32'h55, 2'd0));
      scan(1, 32, 76'h20000, dout, clr);
      chk("hr_dtmcs_before", dout, 76'h1C71);
      chk("hr_clear_pulse", clr, 1'b1);
      chk("hr_valid_drop", valid_a, 1'b0);
      scan(1, 32, 76'h0, dout, clr);
      chk("hr_dtmcs_after", dout, 76'h1071);
      chk("hr_no_clear", clr, 1'b0);
      scan(0, 41, mk_a(0, 0, 0), dout, clr);
      chk("hr_dr", dout, mk_a(0, 0, 0));

      // Reset mid-transaction
      scan(0, 41, mk_a(7'h17, 32'h77, 2'd2), dout, clr);
      chk("mid_valid", valid_a, 1'b1);
      rst = 1'b1; tick();
      chk("mid_rst_valid", valid_a, 1'b0);
      rst = 1'b0; tick();
      chk("mid_post_valid", valid_a, 1'b0);
      resp_cycle(64'h1234, 2'd2);
      scan(0, 41, mk_a(0, 0, 0), dout, clr);
      chk("mid_dr", dout, mk_a(0, 0, 0));

      // 10-bit address, 64-bit data instance
      sel_b = 1'b1;
      scan(1, 32, 76'h0, dout, clr);
      chk("b_dtmcs", dout, 76'h10A1);
      scan(0, 76, mk_b(10'h3A5, 64'h0, 2'd1), dout, clr);
      chk("b_req", {valid_b, addr_b, op_b}, {1'b1, 10'h3A5, 2'd1});
      req_ready = 1'b1; tick(); req_ready = 1'b0;
      resp_cycle(64'h0123456789ABCDEF, 2'd0);
      scan(0, 76, mk_b(0, 0, 0), dout, clr);
      chk("b_rd_capture", dout, mk_b(10'h3A5, 64'h0123456789ABCDEF, 2'd0));
      sel_b = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
